// File: rtl/regfile_pkg.sv
// Shared constants and packed-bus slice helpers
// for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int RST_VAL    = 0;

  // Low bit of slice k in a bus of w-wide fields.
  function automatic int slice_lo(int k, int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: register mux, write bypass
// and pending-bit qualification.
// Ports: i_rst_n, i_rr, i_regs, i_pend,
//   i_wen/i_rw/i_busw (write ports),
//   o_busr, o_busy.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 1 << ADDR_W
) (
  input  logic                     i_rst_n,
  input  logic [ADDR_W-1:0]        i_rr,
  input  logic [DEPTH*DATA_W-1:0]  i_regs,
  input  logic [DEPTH-1:0]         i_pend,
  input  logic [NUM_WR-1:0]        i_wen,
  input  logic [NUM_WR*ADDR_W-1:0] i_rw,
  input  logic [NUM_WR*DATA_W-1:0] i_busw,
  output logic [DATA_W-1:0]        o_busr,
  output logic                     o_busy
);

  logic [DATA_W-1:0] w_data;
  logic              w_hit;

  always_comb begin
    w_data = i_regs[slice_lo(int'(i_rr), DATA_W) +: DATA_W];
    w_hit  = 1'b0;
    // Later ports override: highest index wins.
    for (int k = 0; k < NUM_WR; k++) begin
      if (i_wen[k] &&
          i_rw[slice_lo(k, ADDR_W) +: ADDR_W] == i_rr) begin
        w_hit  = 1'b1;
        w_data = i_busw[slice_lo(k, DATA_W) +: DATA_W];
      end
    end
    if ((ZERO_REG != 0) && (i_rr == '0))
      w_data = '0;
  end

  always_comb begin
    o_busr = '0;
    o_busy = 1'b0;
    if (i_rst_n) begin
      o_busr = w_data;
      o_busy = i_pend[i_rr] & ~w_hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass
// and per-register pending scoreboard.
// Ports: Clk, rst (async low), WEN/RW/busW,
//   RR/busR/rd_busy, sb_set/sb_addr/sb_flush.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        WEN,
  input  logic [NUM_WR*ADDR_W-1:0] RW,
  input  logic [NUM_WR*DATA_W-1:0] busW,
  input  logic [NUM_RD*ADDR_W-1:0] RR,
  output logic [NUM_RD*DATA_W-1:0] busR,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     sb_flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       r_regs [DEPTH];
  logic [DEPTH-1:0]        r_pend;
  logic [DEPTH-1:0]        w_pend_nxt;
  logic [DEPTH*DATA_W-1:0] w_regs;
  logic [ADDR_W-1:0]       w_rw [NUM_WR];
  logic [DATA_W-1:0]       w_bw [NUM_WR];
  logic [NUM_WR-1:0]       w_wok;
  logic                    w_set_ok;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign w_rw[k] = RW[k*ADDR_W +: ADDR_W];
    assign w_bw[k] = busW[k*DATA_W +: DATA_W];
    // Writes to a hardwired zero register are dropped.
    assign w_wok[k] = WEN[k] &
      ~((ZERO_REG != 0) && (w_rw[k] == '0));
  end

  for (genvar d = 0; d < DEPTH; d++) begin : g_flat
    assign w_regs[d*DATA_W +: DATA_W] = r_regs[d];
  end

  assign w_set_ok = sb_set &
    ~((ZERO_REG != 0) && (sb_addr == '0));

  // Flush, then writeback clears, then issue set.
  always_comb begin
    w_pend_nxt = r_pend;
    if (sb_flush)
      w_pend_nxt = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (w_wok[k])
        w_pend_nxt[w_rw[k]] = 1'b0;
    end
    if (w_set_ok)
      w_pend_nxt[sb_addr] = 1'b1;
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < DEPTH; d++)
        r_regs[d] <= DATA_W'(RST_VAL);
      r_pend <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (w_wok[k])
          r_regs[w_rw[k]] <= w_bw[k];
      end
      r_pend <= w_pend_nxt;
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .DEPTH    (DEPTH)
    ) u_rd (
      .i_rst_n (rst),
      .i_rr    (RR[j*ADDR_W +: ADDR_W]),
      .i_regs  (w_regs),
      .i_pend  (r_pend),
      .i_wen   (WEN),
      .i_rw    (RW),
      .i_busw  (busW),
      .o_busr  (busR[j*DATA_W +: DATA_W]),
      .o_busy  (rd_busy[j])
    );
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read CPU register file.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with same-cycle write-to-read bypass and an optional hardwired zero register.
- Adds a per-register pending scoreboard, so the pipeline can detect RAW hazards on registers whose producer has not yet written back.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
DATA_W, 32, data width of every register
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
Clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
WEN  in  NUM_WR  per-port write enable
RW  in  NUM_WR*ADDR_W  write addresses; port k at bits [k*ADDR_W +: ADDR_W]
busW  in  NUM_WR*DATA_W  write data, packed as RW
RR  in  NUM_RD*ADDR_W  read addresses, packed
busR  out  NUM_RD*DATA_W  read data, packed
rd_busy  out  NUM_RD  pending bit of each read port's register
sb_set  in  1  mark register sb_addr pending (instruction issued)
sb_addr  in  ADDR_W  register to mark pending
sb_flush  in  1  clear all pending bits (pipeline flush)

Behaviour:
- Reset:
  - rst low asynchronously clears all DEPTH registers and all pending bits.
  - While in reset, busR = 0 on every port and rd_busy = 0.
  - Writes and sb_set presented during reset are ignored.
  - Release of reset is synchronised by the integrator, not by this block.
- Write (rising Clk, rst high):
  - For each k with WEN[k]=1, reg[RW_k] <= busW_k.
  - If several enabled ports target the same address, the highest-index port wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, zero latency):
  - busR_j = reg[RR_j].
  - Bypass: if any enabled write port has RW_k == RR_j, busR_j = busW_k of the highest such k.
  - With ZERO_REG=1, RR_j == 0 always yields 0, even with a matching write.
  - With ZERO_REG=0, register 0 is bypassed like any other register.
- Scoreboard: pending[DEPTH] flop vector. Next-state evaluation order per cycle:
  1. sb_flush=1 clears all bits;
  2. each enabled write clears pending[RW_k];
  3. sb_set=1 sets pending[sb_addr].
  - A later step overrides an earlier one. Consequences:
    - A set and a clear of the same register in one cycle leaves it pending (new producer).
    - Flush together with set leaves only sb_addr pending.
  - With ZERO_REG=1, pending[0] is never set.
- rd_busy_j = pending[RR_j] AND NOT (some enabled write this cycle targets RR_j).
  - A same-cycle writeback therefore reports not busy, consistent with the bypass.
  - rd_busy_j does not look ahead at sb_set in the same cycle.
- Setting an already-pending register leaves it pending. There is no counting; one outstanding producer per register.
- Hold: registers without an enabled write and pending bits without set/clear/flush keep their value.
- Address range: every address value is in range (DEPTH = 2**ADDR_W), so no out-of-range handling is needed.

Decomposition:
- Shared package regfile_pkg, containing:
  - default DATA_W/ADDR_W constants;
  - the pack/unpack slice helpers (functions returning port k's slice);
  - a localparam for the reset value (0).
- One natural sub-module, regfile_rd_port:
  - one read mux plus bypass compare chain and busy qualification;
  - instantiated NUM_RD times in a generate loop.
- The write array and scoreboard stay in the top module.

Test Plan:
1. Reset: assert rst=0 mid-traffic with WEN=2'b11 -> all busR=0 and rd_busy=0 immediately (without waiting for Clk); after release, read of addresses 1..31 returns 0.
2. Write then read: write port0 R5=0xDEADBEEF, next cycle RR0=5 -> busR0=0xDEADBEEF; with ZERO_REG=1, write R0=0x1234, then read R0 -> 0.
3. Bypass and priority: same cycle WEN=2'b11, RW0=RW1=7, busW0=0xAAAA0000, busW1=0x5555FFFF, RR0=7 -> busR0=0x5555FFFF combinationally; next cycle reg[7] reads 0x5555FFFF.
4. Scoreboard: sb_set addr 9 -> next cycle RR1=9 gives rd_busy1=1. Writeback to 9 with data 0x42 -> that cycle rd_busy1=0 and busR1=0x42; next cycle pending[9]=0.
5. Simultaneous set/clear: pending[3]=1, then in one cycle write R3 and sb_set addr 3 -> after the edge rd_busy for RR=3 is 1. Then sb_flush=1 with sb_set addr 4 -> only register 4 is pending.
6. Parametrisation: DATA_W=64, ADDR_W=3, NUM_RD=4, NUM_WR=1, ZERO_REG=0 -> write R0=0x0123456789ABCDEF, then all four ports reading 0 return that value; random write/read regression against a reference model for 10k cycles.
